// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the ALU command sequencer.
package alu_pkg;

  localparam int unsigned ALU_RES_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL_START,
    ST_MUL_WAIT,
    ST_RESULT
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl_mul_watchdog.sv
// Multiplier watchdog: counts MUL_WAIT cycles and flags the last permitted one.
module mul_watchdog #(
  parameter int unsigned MUL_TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic first_cycle,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Expires during the MUL_TIMEOUT-th enabled cycle, i.e. as the count reaches the limit.
  assign first_cycle = (cnt == '0);
  assign expired     = en && (cnt == 8'(MUL_TIMEOUT - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of the 4-bit ALU: accepts a command, drives the ALU,
// waits for the result (or multiplier Done / watchdog) and returns a response.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = 32,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Cmd_valid,
  output logic                 Cmd_ready,
  input  logic [1:0]           Cmd_op,
  input  logic [3:0]           Cmd_a,
  input  logic [3:0]           Cmd_b,
  output logic                 Res_valid,
  input  logic                 Res_ready,
  output logic [ALU_RES_W-1:0] Res_data,
  output logic                 Res_cout,
  output logic                 Res_err,
  output logic [3:0]           Alu_A,
  output logic [3:0]           Alu_B,
  output logic [1:0]           Alu_Select,
  output logic                 Alu_Init,
  input  logic [ALU_RES_W-1:0] Alu_Sal,
  input  logic                 Alu_Cout,
  input  logic                 Alu_Done,
  output logic                 Busy,
  output logic [CNT_W-1:0]     Op_count
);

  state_e state, state_nxt;
  logic   wd_first, wd_expired;
  logic   mul_done, mul_tmo;

  mul_watchdog #(
    .MUL_TIMEOUT(MUL_TIMEOUT)
  ) u_mul_watchdog (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .clr        (state == ST_MUL_START),
    .en         (state == ST_MUL_WAIT),
    .first_cycle(wd_first),
    .expired    (wd_expired)
  );

  // A Done on the first wait cycle may be left over from the previous multiply.
  assign mul_done = (state == ST_MUL_WAIT) && Alu_Done && !wd_first;
  assign mul_tmo  = (state == ST_MUL_WAIT) && wd_expired;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (Cmd_valid) state_nxt = (Cmd_op == OP_MUL) ? ST_MUL_START : ST_EXEC;
      ST_EXEC:      state_nxt = ST_RESULT;
      ST_MUL_START: state_nxt = ST_MUL_WAIT;
      ST_MUL_WAIT:  if (mul_done || mul_tmo) state_nxt = ST_RESULT;
      ST_RESULT:    if (Res_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs are registered from the next state so they read 0 in reset
  // and otherwise track the current state exactly.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      Cmd_ready <= 1'b0;
      Busy      <= 1'b0;
      Res_valid <= 1'b0;
      Alu_Init  <= 1'b0;
    end else begin
      state     <= state_nxt;
      Cmd_ready <= (state_nxt == ST_IDLE);
      Busy      <= (state_nxt != ST_IDLE);
      Res_valid <= (state_nxt == ST_RESULT);
      Alu_Init  <= (state_nxt == ST_MUL_START);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Alu_A      <= '0;
      Alu_B      <= '0;
      Alu_Select <= '0;
      Res_data   <= '0;
      Res_cout   <= 1'b0;
      Res_err    <= 1'b0;
      Op_count   <= '0;
    end else begin
      if (state == ST_IDLE && Cmd_valid) begin
        Alu_A      <= Cmd_a;
        Alu_B      <= Cmd_b;
        Alu_Select <= Cmd_op;
      end

      if (state == ST_EXEC) begin
        Res_data <= {4'h0, Alu_Sal[3:0]};
        Res_cout <= (Alu_Select == OP_AND) ? 1'b0 : Alu_Cout;
        Res_err  <= 1'b0;
      end else if (mul_done) begin
        Res_data <= Alu_Sal;
        Res_cout <= 1'b0;
        Res_err  <= 1'b0;
      end else if (mul_tmo) begin
        Res_data <= '0;
        Res_cout <= 1'b0;
        Res_err  <= 1'b1;
      end

      if (state == ST_RESULT && Res_ready) begin
        Op_count <= Op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural 4-bit ALU beside it.
module tb_alu_seq_ctrl;

  localparam int unsigned TMO = 6;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Cmd_valid = 1'b0;
  logic       Cmd_ready;
  logic [1:0] Cmd_op = '0;
  logic [3:0] Cmd_a = '0;
  logic [3:0] Cmd_b = '0;
  logic       Res_valid;
  logic       Res_ready = 1'b0;
  logic [7:0] Res_data;
  logic       Res_cout;
  logic       Res_err;
  logic [3:0] Alu_A;
  logic [3:0] Alu_B;
  logic [1:0] Alu_Select;
  logic       Alu_Init;
  logic [7:0] Alu_Sal;
  logic       Alu_Cout;
  logic       Alu_Done;
  logic       Busy;
  logic [7:0] Op_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  alu_seq_ctrl #(
    .MUL_TIMEOUT(TMO),
    .CNT_W      (8)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Cmd_valid (Cmd_valid),
    .Cmd_ready (Cmd_ready),
    .Cmd_op    (Cmd_op),
    .Cmd_a     (Cmd_a),
    .Cmd_b     (Cmd_b),
    .Res_valid (Res_valid),
    .Res_ready (Res_ready),
    .Res_data  (Res_data),
    .Res_cout  (Res_cout),
    .Res_err   (Res_err),
    .Alu_A     (Alu_A),
    .Alu_B     (Alu_B),
    .Alu_Select(Alu_Select),
    .Alu_Init  (Alu_Init),
    .Alu_Sal   (Alu_Sal),
    .Alu_Cout  (Alu_Cout),
    .Alu_Done  (Alu_Done),
    .Busy      (Busy),
    .Op_count  (Op_count)
  );

  // ALU model: upper Sal nibble and Cout on mul/and carry junk the sequencer must mask.
  logic [7:0] mul_res  = '0;
  logic       mul_done = 1'b0;
  logic       mul_busy = 1'b0;
  int         mul_cnt  = 0;
  bit         hang     = 1'b0;
  logic [4:0] sum5, dif5;

  always_comb begin
    sum5 = {1'b0, Alu_A} + {1'b0, Alu_B};
    dif5 = {1'b0, Alu_A} - {1'b0, Alu_B};
    Alu_Sal  = '0;
    Alu_Cout = 1'b0;
    case (Alu_Select)
      2'b00:   begin Alu_Sal = {4'hA, sum5[3:0]};    Alu_Cout = sum5[4]; end
      2'b01:   begin Alu_Sal = {4'hA, dif5[3:0]};    Alu_Cout = dif5[4]; end
      2'b10:   begin Alu_Sal = mul_res;              Alu_Cout = 1'b1;    end
      default: begin Alu_Sal = {4'hA, Alu_A & Alu_B}; Alu_Cout = 1'b1;   end
    endcase
    Alu_Done = mul_done;
  end

  // In hang mode Done is left stale for one cycle after Init, then never asserts.
  always @(posedge Clk) begin
    if (Alu_Init) begin
      mul_busy <= 1'b1;
      mul_cnt  <= 0;
      if (!hang) mul_done <= 1'b0;
    end else if (mul_busy) begin
      if (hang) begin
        mul_done <= 1'b0;
      end else if (mul_cnt == 3) begin
        mul_done <= 1'b1;
        mul_busy <= 1'b0;
        mul_res  <= Alu_A * Alu_B;
      end else begin
        mul_cnt <= mul_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    Cmd_op    = op;
    Cmd_a     = a;
    Cmd_b     = b;
    Cmd_valid = 1'b1;
    chk("cmd_ready_at_issue", 32'(Cmd_ready), 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    Cmd_valid = 1'b0;
  endtask

  // lat counts cycles from the accept cycle to the first cycle with Res_valid high.
  task automatic wait_res(output int lat, output int inits, output bit dseen);
    lat   = 1;
    inits = 0;
    dseen = 1'b0;
    while (lat < 200) begin
      inits += int'(Alu_Init);
      if (Res_valid) break;
      dseen |= Alu_Done;
      @(negedge Clk);
      lat++;
    end
    if (!Res_valid) chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume(input logic [7:0] exp_cnt);
    Res_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Res_ready = 1'b0;
    chk("res_valid_after_consume", 32'(Res_valid), 32'd0);
    chk("op_count", 32'(Op_count), 32'(exp_cnt));
    chk("cmd_ready_after_consume", 32'(Cmd_ready), 32'd1);
  endtask

  int lat, inits;
  bit dseen;

  initial begin
    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_cmd_ready", 32'(Cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(Res_valid), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_op_count", 32'(Op_count), 32'd0);
    chk("rst_res_data", 32'(Res_data), 32'd0);
    Rst_n = 1'b1;
    chk("cmd_ready_before_edge", 32'(Cmd_ready), 32'd0);
    @(negedge Clk);
    chk("cmd_ready_after_edge", 32'(Cmd_ready), 32'd1);

    // Add 9+8
    issue(2'b00, 4'd9, 4'd8);
    chk("add_busy", 32'(Busy), 32'd1);
    wait_res(lat, inits, dseen);
    chk("add_latency", 32'(lat), 32'd2);
    chk("add_data", 32'(Res_data), 32'h01);
    chk("add_cout", 32'(Res_cout), 32'd1);
    chk("add_err", 32'(Res_err), 32'd0);
    chk("add_op_count_pre", 32'(Op_count), 32'd0);
    consume(8'd1);

    // Sub 7-2 then AND C&A back-to-back with Res_ready held high
    Res_ready = 1'b1;
    issue(2'b01, 4'd7, 4'd2);
    chk("sub_cmd_ready_exec", 32'(Cmd_ready), 32'd0);
    wait_res(lat, inits, dseen);
    chk("sub_latency", 32'(lat), 32'd2);
    chk("sub_data", 32'(Res_data), 32'h05);
    chk("sub_cout", 32'(Res_cout), 32'd0);
    chk("sub_cmd_ready_result", 32'(Cmd_ready), 32'd0);
    @(negedge Clk);
    chk("sub_op_count", 32'(Op_count), 32'd2);
    issue(2'b11, 4'hC, 4'hA);
    wait_res(lat, inits, dseen);
    chk("and_data", 32'(Res_data), 32'h08);
    chk("and_cout", 32'(Res_cout), 32'd0);
    @(negedge Clk);
    Res_ready = 1'b0;
    chk("and_op_count", 32'(Op_count), 32'd3);

    // Mul 15*15, then 5 cycles of backpressure
    issue(2'b10, 4'hF, 4'hF);
    wait_res(lat, inits, dseen);
    chk("mul_latency", 32'(lat), 32'd7);
    chk("mul_init_pulses", 32'(inits), 32'd1);
    chk("mul_done_before_valid", 32'(dseen), 32'd1);
    chk("mul_data", 32'(Res_data), 32'hE1);
    chk("mul_cout", 32'(Res_cout), 32'd0);
    chk("mul_err", 32'(Res_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      Cmd_valid = 1'b1;
      Cmd_op    = 2'b00;
      Cmd_a     = 4'd3;
      Cmd_b     = 4'd3;
      @(negedge Clk);
      chk("bp_res_valid", 32'(Res_valid), 32'd1);
      chk("bp_res_data", 32'(Res_data), 32'hE1);
      chk("bp_alu_pins", {20'd0, Alu_A, Alu_B, 2'd0, Alu_Select}, {20'd0, 4'hF, 4'hF, 2'd0, 2'b10});
      chk("bp_cmd_ready", 32'(Cmd_ready), 32'd0);
      chk("bp_op_count", 32'(Op_count), 32'd3);
    end
    Cmd_valid = 1'b0;
    consume(8'd4);
    chk("alu_a_after_bp", 32'(Alu_A), 32'hF);

    // Timeout with a stale Done left over from the previous multiply
    hang = 1'b1;
    chk("stale_done_present", 32'(Alu_Done), 32'd1);
    issue(2'b10, 4'd3, 4'd5);
    wait_res(lat, inits, dseen);
    chk("tmo_latency", 32'(lat), 32'(TMO + 2));
    chk("tmo_data", 32'(Res_data), 32'h00);
    chk("tmo_err", 32'(Res_err), 32'd1);
    chk("tmo_cout", 32'(Res_cout), 32'd0);
    consume(8'd5);

    // Asynchronous reset mid-MUL_WAIT
    issue(2'b10, 4'd2, 4'd2);
    repeat (3) @(negedge Clk);
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_outputs", {24'd0, Cmd_ready, Res_valid, Alu_Init, Res_err, Res_cout, Alu_Select, 1'b0},
        32'd0);
    chk("arst_alu_ab", {24'd0, Alu_A, Alu_B}, 32'd0);
    chk("arst_op_count", 32'(Op_count), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    hang  = 1'b0;
    @(negedge Clk);
    chk("post_rst_cmd_ready", 32'(Cmd_ready), 32'd1);
    chk("post_rst_op_count", 32'(Op_count), 32'd0);
    issue(2'b00, 4'd1, 4'd1);
    wait_res(lat, inits, dseen);
    chk("post_rst_add_data", 32'(Res_data), 32'h02);
    chk("post_rst_add_cout", 32'(Res_cout), 32'd0);
    consume(8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
